// File: rtl/data_sampling_mv.sv
// data_sampling_mv
// Oversampled UART receive bit sampler. RX_IN is first passed through a
// reset-to-idle synchroniser; rx_sync is then sampled SAMPLES times around
// the middle of each bit, and a majority vote produces the bit value. The
// vote result is flagged noisy when the samples were not unanimous. A
// Prescale that is odd or too small to hold the window raises cfg_err and
// suppresses sampling.
//
// Ports
//   CLK          in   oversampling clock
//   RST          in   asynchronous active-low reset
//   RX_IN        in   serial line, asynchronous to CLK
//   Prescale     in   oversampling ratio (edge_cnt period)
//   edge_cnt     in   position within the current bit, 0..Prescale-1
//   dat_samp_en  in   sampling enable from the RX FSM
//   rx_sync      out  synchronised RX_IN (start-edge detection must use this)
//   sampled_bit  out  voted bit value, held until the next vote
//   sample_valid out  one-cycle pulse, sampled_bit updated this cycle
//   noise_err    out  with sample_valid: samples were not unanimous
//   cfg_err      out  registered: Prescale illegal for SAMPLES
module data_sampling_mv #(
    parameter int SAMPLES        = 3,
    parameter int PRESCALE_WIDTH = 6,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic [PRESCALE_WIDTH-1:0] edge_cnt,
    input  logic                      dat_samp_en,
    output logic                      rx_sync,
    output logic                      sampled_bit,
    output logic                      sample_valid,
    output logic                      noise_err,
    output logic                      cfg_err
);

    localparam int CNT_W = $clog2(SAMPLES + 1);
    localparam int HALF  = (SAMPLES - 1) / 2;
    localparam logic [PRESCALE_WIDTH-1:0] HALF_W       = PRESCALE_WIDTH'(HALF);
    localparam logic [PRESCALE_WIDTH-1:0] MIN_PRESCALE = PRESCALE_WIDTH'(2 * SAMPLES + 2);
    localparam logic [PRESCALE_WIDTH-1:0] ONE_W        = PRESCALE_WIDTH'(1);
    localparam logic [CNT_W-1:0]          HALF_C       = CNT_W'(HALF);
    localparam logic [CNT_W-1:0]          ALL_C        = CNT_W'(SAMPLES);
    localparam logic [CNT_W-1:0]          LAST_C       = CNT_W'(SAMPLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        VOTE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic                      w_rx;
    logic [PRESCALE_WIDTH-1:0] w_mid;
    logic [PRESCALE_WIDTH-1:0] w_win_start;
    logic [PRESCALE_WIDTH-1:0] w_win_end;
    logic                      w_take;
    logic                      w_vote;
    logic                      w_abort;
    logic [CNT_W-1:0]          w_ones_next;

    logic                      r_cfg_err;
    logic                      r_sampled_bit;
    logic                      r_sample_valid;
    logic                      r_noise_err;
    logic [CNT_W-1:0]          r_samp_cnt;
    logic [CNT_W-1:0]          r_ones_cnt;
    logic [PRESCALE_WIDTH-1:0] r_prev_cnt;
    logic [PRESCALE_WIDTH-1:0] r_win_prescale;

    // Synchroniser on the asynchronous serial line. It resets to 1 so that a
    // reset never looks like a start edge to the logic downstream.
    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign w_rx = RX_IN;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] r_sync;

            always_ff @(posedge CLK or negedge RST) begin
                if (!RST) begin
                    r_sync <= '1;
                end else begin
                    r_sync[0] <= RX_IN;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        r_sync[i] <= r_sync[i-1];
                    end
                end
            end

            assign w_rx = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    // Sampling window centred on the middle of the bit.
    assign w_mid       = Prescale >> 1;
    assign w_win_start = w_mid - HALF_W;
    assign w_win_end   = w_mid + HALF_W;
    assign w_ones_next = r_ones_cnt + CNT_W'(w_rx);

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Window tracking. A window only completes when edge_cnt walks through
    // it one step per cycle with the same Prescale it started with; any
    // break in that (enable drop, jump, wrap to 0, Prescale change, config
    // error) throws the partial window away. The vote happens on the edge
    // that captures the last sample, so VOTE is the cycle the result is
    // visible and sampling is idle.
    always_comb begin
        w_state_next = r_state;
        w_take       = 1'b0;
        w_vote       = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            IDLE: begin
                if (dat_samp_en && !r_cfg_err && edge_cnt == w_win_start) begin
                    w_take = 1'b1;
                    if (edge_cnt == w_win_end) begin
                        w_vote       = 1'b1;
                        w_state_next = VOTE;
                    end else begin
                        w_state_next = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (!dat_samp_en || r_cfg_err || edge_cnt == '0 ||
                    Prescale != r_win_prescale || edge_cnt != r_prev_cnt + ONE_W) begin
                    w_abort      = 1'b1;
                    w_state_next = IDLE;
                end else if (edge_cnt == w_win_end) begin
                    if (r_samp_cnt == LAST_C) begin
                        w_take       = 1'b1;
                        w_vote       = 1'b1;
                        w_state_next = VOTE;
                    end else begin
                        w_abort      = 1'b1;
                        w_state_next = IDLE;
                    end
                end else begin
                    w_take = 1'b1;
                end
            end
            VOTE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Accumulators, vote result and configuration check. sample_valid and
    // noise_err default low so they only ever form a single-cycle pulse;
    // sampled_bit is left alone unless a vote completes.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_cfg_err      <= 1'b0;
            r_sampled_bit  <= 1'b0;
            r_sample_valid <= 1'b0;
            r_noise_err    <= 1'b0;
            r_samp_cnt     <= '0;
            r_ones_cnt     <= '0;
            r_prev_cnt     <= '0;
            r_win_prescale <= '0;
        end else begin
            r_cfg_err      <= Prescale[0] || (Prescale < MIN_PRESCALE);
            r_sample_valid <= 1'b0;
            r_noise_err    <= 1'b0;
            if (w_vote) begin
                r_sampled_bit  <= (w_ones_next > HALF_C);
                r_noise_err    <= (w_ones_next != '0) && (w_ones_next != ALL_C);
                r_sample_valid <= 1'b1;
                r_samp_cnt     <= '0;
                r_ones_cnt     <= '0;
            end else if (w_take) begin
                r_samp_cnt <= r_samp_cnt + CNT_W'(1);
                r_ones_cnt <= w_ones_next;
            end else if (w_abort) begin
                r_samp_cnt <= '0;
                r_ones_cnt <= '0;
            end
            if (w_take) begin
                r_prev_cnt     <= edge_cnt;
                r_win_prescale <= Prescale;
            end
        end
    end

    assign rx_sync      = w_rx;
    assign sampled_bit  = r_sampled_bit;
    assign sample_valid = r_sample_valid;
    assign noise_err    = r_noise_err;
    assign cfg_err      = r_cfg_err;

endmodule

// File: tb/tb_data_sampling_mv.sv
// tb_data_sampling_mv
// Drives two samplers (3-vote and 5-vote) from the same stimulus and compares
// both against a per-bit window model, a hand-written vector table and a few
// directed multi-cycle sequences.
module tb_data_sampling_mv;

   logic       CLK = 1'b0;
   logic       RST;
   logic       RX_IN;
   logic [5:0] Prescale;
   logic [5:0] edge_cnt;
   logic       dat_samp_en;
   logic       rxSync3, bit3, valid3, noise3, cfg3;
   logic       rxSync5, bit5, valid5, noise5, cfg5;

   data_sampling_mv #(.SAMPLES(3), .PRESCALE_WIDTH(6), .SYNC_STAGES(2)) dut3 (
      .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale), .edge_cnt(edge_cnt),
      .dat_samp_en(dat_samp_en), .rx_sync(rxSync3), .sampled_bit(bit3),
      .sample_valid(valid3), .noise_err(noise3), .cfg_err(cfg3)
   );

   data_sampling_mv #(.SAMPLES(5), .PRESCALE_WIDTH(6), .SYNC_STAGES(2)) dut5 (
      .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale), .edge_cnt(edge_cnt),
      .dat_samp_en(dat_samp_en), .rx_sync(rxSync5), .sampled_bit(bit5),
      .sample_valid(valid5), .noise_err(noise5), .cfg_err(cfg5)
   );

   // Free-running oversampling clock.
   always #5 CLK = ~CLK;

   typedef struct {
      bit en;
      int p;
      int cnt;
      bit rxs;
      bit v3;
      bit b3;
      bit n3;
      bit v5;
      bit b5;
      bit n5;
      bit cfg;
   } vec_t;

   vec_t vecs[$];
   bit   curB3;
   bit   curB5;

   int nChecks;
   int nFails;

   int mLen[2];
   int mOnes[2];
   int mLast[2];
   int mP[2];
   bit mDead[2];
   bit mCfg[2];
   bit mValid[2];
   bit mBit[2];
   bit mNoise[2];
   bit rh1, rh2, expRx;

   // One compare of a single-bit value.
   task automatic checkOutput(input string name, input logic act, input logic exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // One compare of an integer value.
   task automatic checkCount(input string name, input int act, input int exp);
      nChecks++;
      if (act != exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model reset: idle line history, no window in progress, outputs cleared.
   task automatic modelReset();
      for (int m = 0; m < 2; m++) begin
         mLen[m] = 0; mOnes[m] = 0; mLast[m] = 0; mP[m] = 0;
         mDead[m] = 0; mCfg[m] = 0; mValid[m] = 0; mBit[m] = 0; mNoise[m] = 0;
      end
      rh1 = 1'b1;
      rh2 = 1'b1;
      expRx = 1'b1;
   endtask

   // Window model: a window opens at mid-h, collects one sample per cycle
   // while edge_cnt steps by one under an unchanged Prescale, and votes at
   // mid+h. The cycle after a vote is dead time. cfg is the previous
   // cycle's legality verdict.
   task automatic modelStep(input int m, input int s, input bit en, input int p, input int cnt, input bit rxs);
      int h, mid, ws, we;
      bit voteNow;
      h = (s - 1) / 2;
      mid = p / 2;
      ws = (mid - h) & 63;
      we = (mid + h) & 63;
      voteNow = 1'b0;
      mValid[m] = 1'b0;
      mNoise[m] = 1'b0;
      if (mDead[m]) begin
         mDead[m] = 1'b0;
      end else if (mLen[m] == 0) begin
         if (en && !mCfg[m] && cnt == ws) begin
            mLen[m] = 1; mOnes[m] = int'(rxs); mLast[m] = cnt; mP[m] = p;
            voteNow = (cnt == we);
         end
      end else if (!en || mCfg[m] || cnt == 0 || p != mP[m] || cnt != mLast[m] + 1) begin
         mLen[m] = 0;
         mOnes[m] = 0;
      end else begin
         mLen[m]++;
         mOnes[m] += int'(rxs);
         mLast[m] = cnt;
         voteNow = (cnt == we);
      end
      if (voteNow) begin
         mBit[m] = (2 * mOnes[m] > s);
         mNoise[m] = (mOnes[m] != 0) && (mOnes[m] != s);
         mValid[m] = 1'b1;
         mLen[m] = 0;
         mOnes[m] = 0;
         mDead[m] = 1'b1;
      end
      mCfg[m] = (p % 2 != 0) || (p < 2 * s + 2);
   endtask

   // Drive one cycle from a negedge, let the rising edge take it, advance the
   // model and return at the next negedge ready for sampling.
   task automatic applyStimulus(input bit en, input int p, input int cnt, input bit rx);
      bit rxs;
      dat_samp_en = en;
      Prescale = 6'(p);
      edge_cnt = 6'(cnt);
      RX_IN = rx;
      @(posedge CLK);
      rxs = rh2;
      rh2 = rh1;
      rh1 = rx;
      expRx = rh2;
      modelStep(0, 3, en, p, cnt, rxs);
      modelStep(1, 5, en, p, cnt, rxs);
      @(negedge CLK);
   endtask

   // Compare every output of both samplers against the model.
   task automatic checkModel();
      checkOutput("model rx_sync3", rxSync3, expRx);
      checkOutput("model rx_sync5", rxSync5, expRx);
      checkOutput("model valid3", valid3, mValid[0]);
      checkOutput("model bit3", bit3, mBit[0]);
      checkOutput("model noise3", noise3, mNoise[0]);
      checkOutput("model cfg3", cfg3, mCfg[0]);
      checkOutput("model valid5", valid5, mValid[1]);
      checkOutput("model bit5", bit5, mBit[1]);
      checkOutput("model noise5", noise5, mNoise[1]);
      checkOutput("model cfg5", cfg5, mCfg[1]);
   endtask

   // Append one bit period to the vector table. line holds rx_sync per
   // edge_cnt, enMask dat_samp_en per edge_cnt; vXAt is the row where the
   // vote result is expected (-1 for none).
   task automatic addBit(input int p, input logic [31:0] line, input logic [31:0] enMask,
                         input int v3At, input bit b3, input bit n3,
                         input int v5At, input bit b5, input bit n5, input bit cfgExp);
      vec_t v;
      for (int c = 0; c < p; c++) begin
         v.en = enMask[c];
         v.p = p;
         v.cnt = c;
         v.rxs = line[c];
         v.v3 = (c == v3At);
         if (v.v3) curB3 = b3;
         v.b3 = curB3;
         v.n3 = v.v3 && n3;
         v.v5 = (c == v5At);
         if (v.v5) curB5 = b5;
         v.b5 = curB5;
         v.n5 = v.v5 && n5;
         v.cfg = cfgExp;
         vecs.push_back(v);
      end
   endtask

   vec_t       v;
   bit         rxDrive;
   bit         en;
   bit         rxv;
   int         p, cnt, idx, vc3, vc5, n3, n5;
   int         pList[12] = '{8, 10, 12, 14, 16, 20, 32, 7, 6, 9, 11, 13};
   logic [7:0] data;
   logic [10:0] frame, got3, got5;

   // Main sequence: reset, vector table, directed corner cases, random run.
   initial begin
      nChecks = 0;
      nFails = 0;
      RST = 1'b0;
      RX_IN = 1'b1;
      Prescale = 6'd8;
      edge_cnt = 6'd0;
      dat_samp_en = 1'b0;
      modelReset();
      repeat (3) @(negedge CLK);

      checkOutput("reset rx_sync3", rxSync3, 1'b1);
      checkOutput("reset bit3", bit3, 1'b0);
      checkOutput("reset valid3", valid3, 1'b0);
      checkOutput("reset noise3", noise3, 1'b0);
      checkOutput("reset cfg3", cfg3, 1'b0);
      checkOutput("reset cfg5", cfg5, 1'b0);
      RST = 1'b1;

      curB3 = 1'b0;
      curB5 = 1'b0;
      for (int i = 0; i < 2; i++) begin
         v = '{en: 1'b0, p: 8, cnt: 0, rxs: 1'b1, v3: 1'b0, b3: 1'b0, n3: 1'b0,
               v5: 1'b0, b5: 1'b0, n5: 1'b0, cfg: 1'b0};
         vecs.push_back(v);
      end
      addBit(8,  32'h0000_0000, 32'hFFFF_FFFF,  5, 1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b0);
      addBit(16, 32'h0000_FEFF, 32'hFFFF_FFFF,  9, 1'b1, 1'b1, 10, 1'b1, 1'b1, 1'b0);
      addBit(16, 32'h0000_FEBF, 32'hFFFF_FFFF,  9, 1'b1, 1'b1, 10, 1'b1, 1'b1, 1'b0);
      addBit(16, 32'h0000_0500, 32'hFFFF_FFFF,  9, 1'b0, 1'b1, 10, 1'b0, 1'b1, 1'b0);
      addBit(8,  32'h0000_00FF, 32'h0000_000F, -1, 1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b0);
      addBit(8,  32'h0000_00D7, 32'hFFFF_FFFF,  5, 1'b0, 1'b1, -1, 1'b0, 1'b0, 1'b0);
      addBit(7,  32'h0000_0055, 32'hFFFF_FFFF, -1, 1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b1);
      addBit(6,  32'h0000_002A, 32'hFFFF_FFFF, -1, 1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b1);
      addBit(8,  32'h0000_00FF, 32'hFFFF_FFFF,  5, 1'b1, 1'b0, -1, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         rxDrive = (i + 2 < vecs.size()) ? vecs[i+2].rxs : 1'b1;
         applyStimulus(v.en, v.p, v.cnt, rxDrive);
         checkModel();
         checkOutput($sformatf("tbl[%0d] valid3", i), valid3, v.v3);
         checkOutput($sformatf("tbl[%0d] bit3", i), bit3, v.b3);
         checkOutput($sformatf("tbl[%0d] noise3", i), noise3, v.n3);
         checkOutput($sformatf("tbl[%0d] valid5", i), valid5, v.v5);
         checkOutput($sformatf("tbl[%0d] bit5", i), bit5, v.b5);
         checkOutput($sformatf("tbl[%0d] noise5", i), noise5, v.n5);
         checkOutput($sformatf("tbl[%0d] cfg3", i), cfg3, v.cfg);
      end

      // edge_cnt skips 8 inside both windows: no vote for that bit.
      vc3 = 0;
      vc5 = 0;
      for (int c = 0; c < 16; c++) begin
         if (c != 8) begin
            applyStimulus(1'b1, 16, c, 1'b1);
            checkModel();
            vc3 += int'(valid3);
            vc5 += int'(valid5);
         end
      end
      checkCount("jump valid count3", vc3, 0);
      checkCount("jump valid count5", vc5, 0);

      // The following clean bit votes normally.
      vc3 = 0;
      vc5 = 0;
      for (int c = 0; c < 16; c++) begin
         applyStimulus(1'b1, 16, c, 1'b1);
         checkModel();
         vc3 += int'(valid3);
         vc5 += int'(valid5);
      end
      checkCount("after jump valid count3", vc3, 1);
      checkCount("after jump valid count5", vc5, 1);

      // Reset asserted while the 3-vote sampler is mid-window on a low line.
      for (int c = 0; c < 4; c++) begin
         applyStimulus(1'b1, 8, c, 1'b0);
         checkModel();
      end
      #2 RST = 1'b0;
      #1;
      checkOutput("midreset rx_sync3", rxSync3, 1'b1);
      checkOutput("midreset rx_sync5", rxSync5, 1'b1);
      checkOutput("midreset bit3", bit3, 1'b0);
      checkOutput("midreset bit5", bit5, 1'b0);
      checkOutput("midreset valid3", valid3, 1'b0);
      checkOutput("midreset noise3", noise3, 1'b0);
      checkOutput("midreset cfg5", cfg5, 1'b0);
      modelReset();
      repeat (2) @(negedge CLK);
      RST = 1'b1;

      // 11-bit frame at Prescale 32, RX_IN led by the synchroniser delay.
      data = 8'($urandom);
      frame = {1'b1, ^data, data, 1'b0};
      got3 = '0;
      got5 = '0;
      n3 = 0;
      n5 = 0;
      for (int t = 0; t < 11 * 32; t++) begin
         idx = (t + 2) / 32;
         rxv = (idx < 11) ? frame[idx] : 1'b1;
         applyStimulus(1'b1, 32, t % 32, rxv);
         checkModel();
         if (valid3) begin
            got3 = {bit3, got3[10:1]};
            n3++;
         end
         if (valid5) begin
            got5 = {bit5, got5[10:1]};
            n5++;
         end
      end
      checkCount("frame pulses3", n3, 11);
      checkCount("frame pulses5", n5, 11);
      checkCount("frame bits3", int'(got3), int'(frame));
      checkCount("frame bits5", int'(got5), int'(frame));

      // Random run against the model.
      p = 16;
      cnt = 0;
      en = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 99) < 2) p = pList[$urandom_range(0, 11)];
         if ($urandom_range(0, 99) < 3) en = !en;
         if ($urandom_range(0, 99) < 3) cnt = int'($urandom_range(0, p - 1));
         else cnt = (cnt + 1) % p;
         applyStimulus(en, p, cnt, 1'($urandom_range(0, 1)));
         checkModel();
      end

      $display("[TB] End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
